// File: rtl/alu_exec_stage_if.sv
// Handshake bundle between the issue side, the execute stage and writeback.
// The op-code macros live here so every unit sharing the bus agrees on encoding.
`ifndef ALU_OPS_WIDTH
`define ALU_OPS_WIDTH 4
`define ALU_OP_ADD 4'd0
`define ALU_OP_SUB 4'd1
`define ALU_OP_INC 4'd2
`define ALU_OP_DEC 4'd3
`define ALU_OP_NEG 4'd4
`define ALU_OP_AND 4'd5
`define ALU_OP_OR  4'd6
`define ALU_OP_XOR 4'd7
`define ALU_OP_NOT 4'd8
`define ALU_OP_SHL 4'd9
`define ALU_OP_SHR 4'd10
`endif

interface alu_exec_stage_if #(
  parameter int RD_WIDTH = 5
);
  logic                      in_valid;
  logic                      in_ready;
  logic [`ALU_OPS_WIDTH-1:0] in_op;
  logic [31:0]               in_a;
  logic [31:0]               in_b;
  logic [RD_WIDTH-1:0]       in_rd;
  logic                      out_valid;
  logic                      out_ready;
  logic [31:0]               out_result;
  logic [RD_WIDTH-1:0]       out_rd;
  logic                      out_zero;
  logic                      out_neg;
  logic                      out_carry;
  logic                      out_ovf;

  modport master (
    output in_valid, in_op, in_a, in_b, in_rd, out_ready,
    input  in_ready, out_valid, out_result, out_rd,
           out_zero, out_neg, out_carry, out_ovf
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_rd, out_ready,
    output in_ready, out_valid, out_result, out_rd,
           out_zero, out_neg, out_carry, out_ovf
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Two-stage ALU execute pipeline: S1 holds the operands, S2 holds the result
// and flags; valid/ready at both ends, plus a count of results retired downstream.
`ifndef ALU_OPS_WIDTH
`define ALU_OPS_WIDTH 4
`define ALU_OP_ADD 4'd0
`define ALU_OP_SUB 4'd1
`define ALU_OP_INC 4'd2
`define ALU_OP_DEC 4'd3
`define ALU_OP_NEG 4'd4
`define ALU_OP_AND 4'd5
`define ALU_OP_OR  4'd6
`define ALU_OP_XOR 4'd7
`define ALU_OP_NOT 4'd8
`define ALU_OP_SHL 4'd9
`define ALU_OP_SHR 4'd10
`endif

module alu (
  input  logic [`ALU_OPS_WIDTH-1:0] op,
  input  logic [31:0]               i1,
  input  logic [31:0]               i2,
  output logic [31:0]               result
);
  always_comb begin
    result = i1;
    case (op)
      `ALU_OP_ADD: result = i1 + i2;
      `ALU_OP_SUB: result = i1 - i2;
      `ALU_OP_INC: result = i1 + 32'd1;
      `ALU_OP_DEC: result = i1 - 32'd1;
      `ALU_OP_NEG: result = 32'd0 - i1;
      `ALU_OP_AND: result = i1 & i2;
      `ALU_OP_OR:  result = i1 | i2;
      `ALU_OP_XOR: result = i1 ^ i2;
      `ALU_OP_NOT: result = ~i1;
      `ALU_OP_SHL: result = i1 << i2[4:0];
      `ALU_OP_SHR: result = i1 >> i2[4:0];
      default:     result = i1;
    endcase
  end
endmodule

module alu_exec_stage #(
  parameter int RD_WIDTH  = 5,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  alu_exec_stage_if.slave      bus,
  output logic [CNT_WIDTH-1:0] retired
);
  logic                      s1_valid_q, s1_valid_d;
  logic [`ALU_OPS_WIDTH-1:0] s1_op_q, s1_op_d;
  logic [31:0]               s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [RD_WIDTH-1:0]       s1_rd_q, s1_rd_d;
  logic                      s2_valid_q, s2_valid_d;
  logic [31:0]               s2_result_q, s2_result_d;
  logic [RD_WIDTH-1:0]       s2_rd_q, s2_rd_d;
  logic [3:0]                s2_flags_q, s2_flags_d;
  logic [CNT_WIDTH-1:0]      retired_q, retired_d;

  logic        s2_free, s1_adv, in_ready, accept, out_xfer;
  logic [31:0] alu_result;
  logic        carry, ovf;

  alu u_alu (
    .op     (s1_op_q),
    .i1     (s1_a_q),
    .i2     (s1_b_q),
    .result (alu_result)
  );

  always_comb begin
    s2_free  = !s2_valid_q || bus.out_ready;
    s1_adv   = s1_valid_q && s2_free;
    in_ready = !flush && (!s1_valid_q || s2_free);
    accept   = bus.in_valid && in_ready;
    out_xfer = s2_valid_q && bus.out_ready;
  end

  // Unsigned carry of a+b shows up as a wrapped sum smaller than a.
  always_comb begin
    carry = 1'b0;
    ovf   = 1'b0;
    case (s1_op_q)
      `ALU_OP_ADD: begin
        carry = alu_result < s1_a_q;
        ovf   = (s1_a_q[31] == s1_b_q[31]) && (alu_result[31] != s1_a_q[31]);
      end
      `ALU_OP_SUB: begin
        carry = s1_a_q < s1_b_q;
        ovf   = (s1_a_q[31] != s1_b_q[31]) && (alu_result[31] != s1_a_q[31]);
      end
      `ALU_OP_INC: begin
        carry = &s1_a_q;
        ovf   = s1_a_q == 32'h7FFF_FFFF;
      end
      `ALU_OP_DEC: begin
        carry = s1_a_q == 32'd0;
        ovf   = s1_a_q == 32'h8000_0000;
      end
      `ALU_OP_NEG: begin
        carry = s1_a_q != 32'd0;
        ovf   = s1_a_q == 32'h8000_0000;
      end
      default: ;
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_rd_d     = s1_rd_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_rd_d     = s2_rd_q;
    s2_flags_d  = s2_flags_q;
    retired_d   = retired_q + {{(CNT_WIDTH-1){1'b0}}, out_xfer};

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = bus.in_op;
      s1_a_d     = bus.in_a;
      s1_b_d     = bus.in_b;
      s1_rd_d    = bus.in_rd;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    // S2 refills on the same edge it drains, so streaming has no bubble.
    if (s1_adv) begin
      s2_valid_d  = 1'b1;
      s2_result_d = alu_result;
      s2_rd_d     = s1_rd_q;
      s2_flags_d  = {alu_result == 32'd0, alu_result[31], carry, ovf};
    end else if (out_xfer) begin
      s2_valid_d = 1'b0;
    end

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_rd_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_rd_q     <= '0;
      s2_flags_q  <= '0;
      retired_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_rd_q     <= s1_rd_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_rd_q     <= s2_rd_d;
      s2_flags_q  <= s2_flags_d;
      retired_q   <= retired_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = s2_valid_q;
  assign bus.out_result = s2_result_q;
  assign bus.out_rd     = s2_rd_q;
  assign bus.out_zero   = s2_flags_q[3];
  assign bus.out_neg    = s2_flags_q[2];
  assign bus.out_carry  = s2_flags_q[1];
  assign bus.out_ovf    = s2_flags_q[0];
  assign retired        = retired_q;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboarded bench for alu_exec_stage: the driver pushes reference results on
// accept, an independent monitor compares every presented output in order.
module tb_alu_exec_stage;
  localparam int RDW = 5;
  localparam int CW  = 4;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_INC = 4'd2, OP_DEC = 4'd3,
                         OP_NEG = 4'd4, OP_AND = 4'd5, OP_OR = 4'd6, OP_XOR = 4'd7,
                         OP_NOT = 4'd8, OP_SHL = 4'd9, OP_SHR = 4'd10;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  typedef logic [RDW+35:0] exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic [CW-1:0] retired;

  alu_exec_stage_if #(.RD_WIDTH(RDW)) bus ();

  alu_exec_stage #(.RD_WIDTH(RDW), .CNT_WIDTH(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .bus     (bus.slave),
    .retired (retired)
  );

  always #5 clk = ~clk;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned rcount = 0;
  bit          rr_en = 0;
  bit          saw_bp = 0;

  function automatic exp_t model(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                 logic [RDW-1:0] rd);
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint s = 0;
    logic [31:0] r;
    bit c = 0, v = 0;
    case (op)
      OP_ADD: begin r = a + b; c = (ua + ub) > 64'hFFFF_FFFF; s = sa + sb; v = s > SMAX || s < SMIN; end
      OP_SUB: begin r = a - b; c = ua < ub; s = sa - sb; v = s > SMAX || s < SMIN; end
      OP_INC: begin r = a + 1; c = (ua + 1) > 64'hFFFF_FFFF; s = sa + 1; v = s > SMAX; end
      OP_DEC: begin r = a - 1; c = ua < 1; s = sa - 1; v = s < SMIN; end
      OP_NEG: begin r = 0 - a; c = ua != 0; s = -sa; v = s > SMAX; end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
      OP_SHL: r = 32'(ua << (ub % 32));
      OP_SHR: r = 32'(ua >> (ub % 32));
      default: r = a;
    endcase
    return {rd, r, r == 32'd0, r[31], c, v};
  endfunction

  function automatic void check(string nm, logic [63:0] act, logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endfunction

  // Monitor: samples just before each rising edge.
  initial forever begin
    @(negedge clk);
    #4;
    if (!rst) begin
      if (bus.in_valid && !bus.in_ready) saw_bp = 1;
      check("retired", 64'(retired), 64'(CW'(rcount)));
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_out: got rd=%h res=%h expected no output", bus.out_rd, bus.out_result);
        end else begin
          check("out", 64'({bus.out_rd, bus.out_result, bus.out_zero, bus.out_neg,
                            bus.out_carry, bus.out_ovf}), 64'(q[0]));
          if (bus.out_ready) void'(q.pop_front());
        end
        if (bus.out_ready) rcount++;
      end
      if (flush) q.delete();
    end
  end

  initial forever begin
    @(negedge clk);
    if (rr_en) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic send(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [RDW-1:0] rd);
    bit acc = 0;
    bus.in_valid = 1; bus.in_op = op; bus.in_a = a; bus.in_b = b; bus.in_rd = rd;
    for (int i = 0; i < 200 && !acc; i++) begin
      #3;
      acc = bus.in_ready;
      if (acc) q.push_back(model(op, a, b, rd));
      @(negedge clk);
    end
    bus.in_valid = 0;
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  task automatic directed(string nm, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                          logic [31:0] er, logic [3:0] ef);
    send(op, a, b, 5'd3);
    #1;
    check({nm, "_cycle1_valid"}, 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    #1;
    check({nm, "_cycle2_valid"}, 64'(bus.out_valid), 64'd1);
    check({nm, "_result"}, 64'(bus.out_result), 64'(er));
    check({nm, "_flags"}, 64'({bus.out_zero, bus.out_neg, bus.out_carry, bus.out_ovf}), 64'(ef));
    drain();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [CW-1:0] r0;
    int n;
    bus.in_valid = 0; bus.in_op = 0; bus.in_a = 0; bus.in_b = 0; bus.in_rd = 0;
    bus.out_ready = 1;
    #1 rst = 1;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_retired", 64'(retired), 64'd0);
    check("rst_result", 64'(bus.out_result), 64'd0);
    check("rst_rd", 64'(bus.out_rd), 64'd0);
    check("rst_flags", 64'({bus.out_zero, bus.out_neg, bus.out_carry, bus.out_ovf}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);

    directed("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b1010);
    directed("sub_ovf", OP_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 4'b0001);
    directed("neg_min", OP_NEG, 32'h8000_0000, 32'd0, 32'h8000_0000, 4'b0111);

    // Eight back-to-back INCs with writeback stalled for cycles 3..6.
    r0 = CW'(rcount);
    saw_bp = 0;
    fork
      begin
        for (int c = 0; c < 30; c++) begin
          bus.out_ready = !(c >= 3 && c <= 6);
          @(negedge clk);
        end
        bus.out_ready = 1;
      end
      begin
        for (int k = 0; k < 8; k++) send(OP_INC, 32'h7FFF_FFFC + k, 32'd0, RDW'(k));
      end
    join
    drain();
    check("inc_backpressure", 64'(saw_bp), 64'd1);
    check("inc_retired", 64'(retired), 64'(CW'(r0 + 4'd8)));

    // Flush with both stages full and a new op on offer.
    bus.out_ready = 0;
    send(OP_XOR, 32'h1234_5678, 32'hFFFF_0000, 5'd1);
    send(OP_OR, 32'h0000_00F0, 32'h0F00_0000, 5'd2);
    r0 = retired;
    #1;
    check("full_out_valid", 64'(bus.out_valid), 64'd1);
    flush = 1;
    bus.in_valid = 1; bus.in_op = OP_ADD; bus.in_a = 32'd7; bus.in_b = 32'd9; bus.in_rd = 5'd9;
    #2;
    check("flush_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    flush = 0;
    bus.in_valid = 0;
    #1;
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_retired", 64'(retired), 64'(r0));
    @(negedge clk);
    #1;
    check("flush_no_accept", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1;
    @(negedge clk);

    rr_en = 1;
    for (int i = 0; i < 300; i++) begin
      send(4'($urandom_range(0, 15)), pick(), pick(), RDW'($urandom));
      if ($urandom_range(0, 5) == 0) @(negedge clk);
    end
    rr_en = 0;
    bus.out_ready = 1;
    drain();

    // Asynchronous reset between edges with a full pipeline.
    bus.out_ready = 0;
    send(OP_AND, 32'hFFFF_FFFF, 32'h00FF_00FF, 5'd4);
    send(OP_SHL, 32'h0000_0001, 32'd31, 5'd5);
    #2 rst = 1;
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_retired", 64'(retired), 64'd0);
    check("mid_rst_result", 64'(bus.out_result), 64'd0);
    q.delete();
    rcount = 0;
    @(negedge clk);
    rst = 0;
    bus.out_ready = 1;
    directed("post_rst_add", OP_ADD, 32'd5, 32'd6, 32'd11, 4'b0000);

    // Counter wrap with a 4-bit retired count.
    n = 15 - int'(rcount % 16);
    for (int i = 0; i < n; i++) send(OP_DEC, 32'(i), 32'd0, RDW'(i));
    drain();
    check("retired_all_ones", 64'(retired), 64'hF);
    send(OP_DEC, 32'd0, 32'd0, 5'd31);
    drain();
    check("retired_wrap", 64'(retired), 64'd0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
